// File: rtl/ex_forward_ctrl_pkg.sv
// Shared constants for EX-stage operand forwarding.
// The forward-select encodings here are the same ones the EX operand muxes decode.
package ex_forward_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/ex_forward_ctrl_fwd_select.sv
// Priority compare for one EX source operand against the MEM and WB slots.
// MEM wins over WB because MEM holds the younger write to the register.
module ex_forward_ctrl_fwd_select
  import ex_forward_ctrl_pkg::*;
#(
  parameter int                    REG_ADDR_W = ex_forward_ctrl_pkg::REG_ADDR_W,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG   = REG_ADDR_W'(ex_forward_ctrl_pkg::ZERO_REG)
) (
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            sel
);

  logic mem_hit;
  logic wb_hit;

  // x0 is never a source: its architectural value is always zero.
  assign mem_hit = mem_valid && mem_regwrite && (mem_rd != ZERO_REG) && (mem_rd == rs);
  assign wb_hit  = wb_valid  && wb_regwrite  && (wb_rd  != ZERO_REG) && (wb_rd  == rs);

  always_comb begin
    sel = FWD_NONE;
    if (ex_valid) begin
      if (mem_hit) begin
        sel = FWD_MEM;
      end else if (wb_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ex_forward_ctrl.sv
// Tracks rd/regwrite of instructions in EX, MEM and WB and derives the EX operand
// forwarding selects plus the load-use stall request for the ID instruction.
module ex_forward_ctrl
  import ex_forward_ctrl_pkg::*;
#(
  parameter int                    REG_ADDR_W = ex_forward_ctrl_pkg::REG_ADDR_W,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG   = REG_ADDR_W'(ex_forward_ctrl_pkg::ZERO_REG)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  output logic [1:0]            forward_a_o,
  output logic [1:0]            forward_b_o,
  output logic                  load_use_stall_o,
  output logic                  ex_valid_o
);

  logic                  ex_valid_reg;
  logic [REG_ADDR_W-1:0] ex_rs1_reg;
  logic [REG_ADDR_W-1:0] ex_rs2_reg;
  logic [REG_ADDR_W-1:0] ex_rd_reg;
  logic                  ex_regwrite_reg;
  logic                  ex_memread_reg;

  logic                  mem_valid_reg;
  logic [REG_ADDR_W-1:0] mem_rd_reg;
  logic                  mem_regwrite_reg;

  logic                  wb_valid_reg;
  logic [REG_ADDR_W-1:0] wb_rd_reg;
  logic                  wb_regwrite_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_reg     <= 1'b0;
      ex_rs1_reg       <= '0;
      ex_rs2_reg       <= '0;
      ex_rd_reg        <= '0;
      ex_regwrite_reg  <= 1'b0;
      ex_memread_reg   <= 1'b0;
      mem_valid_reg    <= 1'b0;
      mem_rd_reg       <= '0;
      mem_regwrite_reg <= 1'b0;
      wb_valid_reg     <= 1'b0;
      wb_rd_reg        <= '0;
      wb_regwrite_reg  <= 1'b0;
    end else if (start_i) begin
      wb_valid_reg     <= mem_valid_reg;
      wb_rd_reg        <= mem_rd_reg;
      wb_regwrite_reg  <= mem_regwrite_reg;
      mem_valid_reg    <= ex_valid_reg;
      mem_rd_reg       <= ex_rd_reg;
      mem_regwrite_reg <= ex_regwrite_reg;
      // A stalled or squashed ID instruction enters EX as an all-zero bubble.
      if (stall_i || flush_i) begin
        ex_valid_reg    <= 1'b0;
        ex_rs1_reg      <= '0;
        ex_rs2_reg      <= '0;
        ex_rd_reg       <= '0;
        ex_regwrite_reg <= 1'b0;
        ex_memread_reg  <= 1'b0;
      end else begin
        ex_valid_reg    <= id_valid_i;
        ex_rs1_reg      <= id_rs1_i;
        ex_rs2_reg      <= id_rs2_i;
        ex_rd_reg       <= id_rd_i;
        ex_regwrite_reg <= id_regwrite_i;
        ex_memread_reg  <= id_memread_i;
      end
    end
  end

  ex_forward_ctrl_fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_fwd_a (
    .ex_valid     (ex_valid_reg),
    .rs           (ex_rs1_reg),
    .mem_valid    (mem_valid_reg),
    .mem_regwrite (mem_regwrite_reg),
    .mem_rd       (mem_rd_reg),
    .wb_valid     (wb_valid_reg),
    .wb_regwrite  (wb_regwrite_reg),
    .wb_rd        (wb_rd_reg),
    .sel          (forward_a_o)
  );

  ex_forward_ctrl_fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_fwd_b (
    .ex_valid     (ex_valid_reg),
    .rs           (ex_rs2_reg),
    .mem_valid    (mem_valid_reg),
    .mem_regwrite (mem_regwrite_reg),
    .mem_rd       (mem_rd_reg),
    .wb_valid     (wb_valid_reg),
    .wb_regwrite  (wb_regwrite_reg),
    .wb_rd        (wb_rd_reg),
    .sel          (forward_b_o)
  );

  // Deliberately independent of stall_i/flush_i so the external stall logic has no loop.
  assign load_use_stall_o = id_valid_i && ex_valid_reg && ex_memread_reg &&
                            (ex_rd_reg != ZERO_REG) &&
                            ((ex_rd_reg == id_rs1_i) || (ex_rd_reg == id_rs2_i));

  assign ex_valid_o = ex_valid_reg;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Directed bench for ex_forward_ctrl: one task per scenario, hand-computed expectations.
module tb_ex_forward_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       stall_i;
  logic       flush_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic [4:0] id_rd_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic [1:0] forward_a_o;
  logic [1:0] forward_b_o;
  logic       load_use_stall_o;
  logic       ex_valid_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  ex_forward_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .id_valid_i       (id_valid_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_rd_i          (id_rd_i),
    .id_regwrite_i    (id_regwrite_i),
    .id_memread_i     (id_memread_i),
    .forward_a_o      (forward_a_o),
    .forward_b_o      (forward_b_o),
    .load_use_stall_o (load_use_stall_o),
    .ex_valid_o       (ex_valid_o)
  );

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_valid_i    = v;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_pipe();
    start_i = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    start_i = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    set_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
    #2;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (forward_a_o !== 2'b00) begin
        mismatched++;
        $display("FAIL reset_fwd_a cyc%0d: got %b expected 00", i, forward_a_o);
      end
      compared++;
      if (forward_b_o !== 2'b00) begin
        mismatched++;
        $display("FAIL reset_fwd_b cyc%0d: got %b expected 00", i, forward_b_o);
      end
      compared++;
      if (load_use_stall_o !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_lu cyc%0d: got %b expected 0", i, load_use_stall_o);
      end
      compared++;
      if (ex_valid_o !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_ex_valid cyc%0d: got %b expected 0", i, ex_valid_o);
      end
      step();
    end
    rst_i = 1'b1;
    #1;
    compared++;
    if (ex_valid_o !== 1'b0 || forward_a_o !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_release: got ex_valid=%b fa=%b expected 0/00", ex_valid_o, forward_a_o);
    end
    $display("reset: rst_i held low 3 cycles then released, outputs idle");
  endtask

  task automatic test_back_to_back();
    // Direct dependency: producer in MEM when consumer in EX.
    clear_pipe();
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0); step();
    compared++;
    if (forward_a_o !== 2'b10 || forward_b_o !== 2'b10) begin
      mismatched++;
      $display("FAIL b2b_gap0: got fa=%b fb=%b expected 10/10", forward_a_o, forward_b_o);
    end
    compared++;
    if (ex_valid_o !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ex_valid: got %b expected 1", ex_valid_o);
    end
    $display("b2b gap0: fa=%b fb=%b", forward_a_o, forward_b_o);

    // One independent instruction between: producer in WB.
    clear_pipe();
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0); step();
    compared++;
    if (forward_a_o !== 2'b01 || forward_b_o !== 2'b01) begin
      mismatched++;
      $display("FAIL b2b_gap1: got fa=%b fb=%b expected 01/01", forward_a_o, forward_b_o);
    end
    $display("b2b gap1: fa=%b fb=%b", forward_a_o, forward_b_o);

    // Two between: producer has retired.
    clear_pipe();
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0); step();
    compared++;
    if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00) begin
      mismatched++;
      $display("FAIL b2b_gap2: got fa=%b fb=%b expected 00/00", forward_a_o, forward_b_o);
    end
    $display("b2b gap2: fa=%b fb=%b", forward_a_o, forward_b_o);
  endtask

  task automatic test_double_hit();
    clear_pipe();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0); step();
    compared++;
    if (forward_a_o !== 2'b10) begin
      mismatched++;
      $display("FAIL double_hit_a: got %b expected 10", forward_a_o);
    end
    compared++;
    if (forward_b_o !== 2'b00) begin
      mismatched++;
      $display("FAIL double_hit_b_x0: got %b expected 00", forward_b_o);
    end
    $display("double hit x7: fa=%b fb=%b", forward_a_o, forward_b_o);

    clear_pipe();
    set_id(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0); step();
    compared++;
    if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00) begin
      mismatched++;
      $display("FAIL x0_dest: got fa=%b fb=%b expected 00/00", forward_a_o, forward_b_o);
    end
    $display("x0 destination: fa=%b fb=%b", forward_a_o, forward_b_o);
  endtask

  task automatic test_load_use();
    clear_pipe();
    set_id(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1); step();
    set_id(1'b1, 5'd3, 5'd8, 5'd10, 1'b1, 1'b0); #1;
    compared++;
    if (load_use_stall_o !== 1'b0) begin
      mismatched++;
      $display("FAIL load_use_nodep: got %b expected 0", load_use_stall_o);
    end
    set_id(1'b1, 5'd3, 5'd9, 5'd10, 1'b1, 1'b0); #1;
    compared++;
    if (load_use_stall_o !== 1'b1) begin
      mismatched++;
      $display("FAIL load_use_rs2: got %b expected 1", load_use_stall_o);
    end
    $display("load x9 in EX, ID rs2=9: load_use=%b", load_use_stall_o);
    stall_i = 1'b1;
    step();
    stall_i = 1'b0;
    compared++;
    if (ex_valid_o !== 1'b0 || load_use_stall_o !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_bubble: got ex_valid=%b lu=%b expected 0/0", ex_valid_o, load_use_stall_o);
    end
    step();
    compared++;
    if (forward_b_o !== 2'b01 || forward_a_o !== 2'b00) begin
      mismatched++;
      $display("FAIL load_fwd_wb: got fa=%b fb=%b expected 00/01", forward_a_o, forward_b_o);
    end
    $display("after stall, consumer in EX: fa=%b fb=%b", forward_a_o, forward_b_o);
  endtask

  task automatic test_flush_freeze();
    clear_pipe();
    flush_i = 1'b1;
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); step();
    flush_i = 1'b0;
    set_id(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0); step();
    compared++;
    if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00 || ex_valid_o !== 1'b1) begin
      mismatched++;
      $display("FAIL flush: got fa=%b fb=%b ex_valid=%b expected 00/00/1",
               forward_a_o, forward_b_o, ex_valid_o);
    end
    $display("flushed x3 producer: fa=%b fb=%b", forward_a_o, forward_b_o);

    clear_pipe();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0); step();
    start_i = 1'b0;
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (forward_a_o !== 2'b10 || forward_b_o !== 2'b00 || ex_valid_o !== 1'b1) begin
        mismatched++;
        $display("FAIL freeze cyc%0d: got fa=%b fb=%b ex_valid=%b expected 10/00/1",
                 i, forward_a_o, forward_b_o, ex_valid_o);
      end
    end
    $display("freeze 3 cycles: fa=%b fb=%b", forward_a_o, forward_b_o);
  endtask

  task automatic test_async_reset();
    // Entered with the frozen state from test_flush_freeze: forward_a = 10.
    #2;
    compared++;
    if (forward_a_o !== 2'b10) begin
      mismatched++;
      $display("FAIL async_pre: got %b expected 10", forward_a_o);
    end
    rst_i = 1'b0;
    #1;
    compared++;
    if (forward_a_o !== 2'b00 || ex_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: got fa=%b ex_valid=%b expected 00/0", forward_a_o, ex_valid_o);
    end
    $display("async reset mid-cycle: fa=%b ex_valid=%b", forward_a_o, ex_valid_o);
    #2;
    rst_i   = 1'b1;
    start_i = 1'b1;
    step();
    compared++;
    if (forward_a_o !== 2'b00 || ex_valid_o !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset_slots: got fa=%b ex_valid=%b expected 00/1", forward_a_o, ex_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_double_hit();
    test_load_use();
    test_flush_freeze();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_forward_ctrl.md
Name: ex_forward_ctrl

Overview:
- Tracks destination-register/write-enable state of in-flight instructions in EX, MEM and WB.
- Produces the 2-bit EX-stage operand forwarding selects that drive the EX operand muxes (00 = ID/EX register data, 10 = MEM ALU result, 01 = WB write data).
- Also flags load-use hazards to the hazard/stall logic.
- Sits between the decode stage and the EX operand muxes of the 5-stage RISC-V pipeline.

Parameters:
REG_ADDR_W, 5, register-index width
ZERO_REG, 0, hardwired-zero register index; never a forwarding source

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  pipeline run enable; 0 freezes all tracking slots
stall_i  input  1  load-use stall in effect; bubble inserted into EX slot
flush_i  input  1  ID instruction squashed (branch taken); bubble inserted into EX slot
id_valid_i  input  1  ID stage holds a real instruction
id_rs1_i  input  REG_ADDR_W  ID source register 1
id_rs2_i  input  REG_ADDR_W  ID source register 2
id_rd_i  input  REG_ADDR_W  ID destination register
id_regwrite_i  input  1  ID instruction writes rd
id_memread_i  input  1  ID instruction is a load
forward_a_o  output  2  select for EX operand A mux
forward_b_o  output  2  select for EX operand B mux
load_use_stall_o  output  1  ID instruction depends on a load currently in EX
ex_valid_o  output  1  EX slot holds a real instruction (debug/observe)

Behaviour:
- Three tracking slots:
  - EX: valid, rs1, rs2, rd, regwrite, memread.
  - MEM: valid, rd, regwrite.
  - WB: valid, rd, regwrite.
- Reset (rst_i low, asynchronous): all slot fields 0. Consequently forward_a_o = forward_b_o = 2'b00, load_use_stall_o = 0, ex_valid_o = 0 while in reset and on first cycle after release.
- Clock edge with start_i = 0: all slots hold.
- Clock edge with start_i = 1: WB <= MEM; MEM <= EX (rd, regwrite, valid).
  - EX <= bubble (all fields 0) if stall_i or flush_i.
  - Else EX <= {id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i}.
- stall_i and flush_i both high: bubble, same as either alone.
- Forward selects are pure functions of slot registers (Moore, no input-to-output path); valid in the same cycle the instruction occupies EX. Per operand X in {rs1→A, rs2→B}:
  - MEM hit = mem.valid & mem.regwrite & mem.rd != ZERO_REG & mem.rd == ex.rsX.
  - WB hit = same test on WB slot.
  - MEM hit → 2'b10; else WB hit → 2'b01; else 2'b00. MEM has priority (newest value).
  - ex.valid = 0 → both selects 2'b00.
  - Encoding 2'b11 never driven.
- Load-use: load_use_stall_o = id_valid_i & ex.valid & ex.memread & ex.rd != ZERO_REG & (ex.rd == id_rs1_i | ex.rd == id_rs2_i).
  - Combinational from ID inputs and EX slot only; no dependency on stall_i or flush_i (no loop through external stall logic).
  - A load in MEM feeding EX is never forwarded from MEM. The stall guarantees the load has reached WB before use; the bench checks for this.
- rs matching the same rd in both MEM and WB: MEM wins.
- Reset asserted mid-operation: all slots cleared immediately; in-flight forwarding information discarded.
- Latency: ID instruction visible in EX slot one start-enabled edge later; forward selects update same cycle.

Decomposition:
- Shared package: FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10; REG_ADDR_W; ZERO_REG. These are shared with the EX operand muxes.
- One sub-module, fwd_select: combinational per-operand priority compare (rs, MEM slot, WB slot → 2-bit select). Instantiated twice (A and B).

Test Plan:
- Reset: hold rst_i low, drive id_rs1 = 5, id_rd = 5, id_regwrite = 1 → forward_a/b = 00, load_use_stall = 0, ex_valid = 0 throughout.
- Back-to-back dependency: add x5 then add using rs1 = 5, rs2 = 5 next cycle → when second is in EX, forward_a = forward_b = 10. One independent instruction between → both 01. Two between → 00.
- Double hit: x7 written by the instructions in both MEM and WB, EX reads rs1 = 7 → forward_a = 10. x0 destination with rd = 0, regwrite = 1 → 00.
- Load-use: load rd = 9 in EX, ID rs2 = 9 → load_use_stall_o = 1. Assert stall_i for one edge → EX bubble, ex_valid = 0. Next cycle the dependent instruction enters EX with the load in WB → forward_b = 01.
- Flush/freeze: flush_i = 1 with id_regwrite = 1, rd = 3 → following consumer of x3 sees no forward from the squashed instruction. start_i = 0 for 3 cycles → slots and selects unchanged.
- Async reset mid-stream: drop rst_i between clock edges while forward_a = 10 → forward_a = 00 immediately, without waiting for a clock edge.
